// File: rtl/btn_press_classifier_if.sv
// ---------------------------------------------------------------------------
// btn_press_classifier_if
// Bundles the debounced button level and the classified event outputs of the
// press classifier so they travel as one port.
//
// Signals
//   din        debounced button level, synchronous to clk, 1 = pressed
//   press      one-cycle pulse at the start of a press
//   short_p    one-cycle pulse on release of a short press
//   long_p     one-cycle pulse when a press becomes long
//   rpt_p      one-cycle auto-repeat pulse while a long press is held
//   held       level, high while a press is in progress
//   press_cnt  wrapping count of short presses
//
// Modports
//   master  drives din, observes the events (debouncer side / bench)
//   slave   consumes din, produces the events (classifier)
// ---------------------------------------------------------------------------
interface btn_press_classifier_if;
    logic       din;
    logic       press;
    logic       short_p;
    logic       long_p;
    logic       rpt_p;
    logic       held;
    logic [7:0] press_cnt;

    modport master (
        output din,
        input  press,
        input  short_p,
        input  long_p,
        input  rpt_p,
        input  held,
        input  press_cnt
    );

    modport slave (
        input  din,
        output press,
        output short_p,
        output long_p,
        output rpt_p,
        output held,
        output press_cnt
    );
endinterface

// File: rtl/btn_press_classifier.sv
// ---------------------------------------------------------------------------
// btn_press_classifier
// Turns the debounced button level into single-cycle, registered event
// pulses: press, short press, long press and auto-repeat while held. It also
// keeps a wrapping 8-bit count of short presses.
//
// Parameters
//   T_LONG    hold length in clocks that makes a press long (>= 2)
//   T_REPEAT  auto-repeat period in clocks once a press is long (>= 2)
//
// Ports
//   clk   system clock, all logic on the rising edge
//   rst   synchronous active-high reset
//   bus   slave side of btn_press_classifier_if (din in, events out)
// ---------------------------------------------------------------------------
module btn_press_classifier #(
    parameter logic [25:0] T_LONG   = 26'h2FA_F080,
    parameter logic [25:0] T_REPEAT = 26'h0BE_BC20
) (
    input  logic                      clk,
    input  logic                      rst,
    btn_press_classifier_if.slave     bus
);

    // Terminal counts; cnt runs 0 .. T-1 so the event lands exactly T clocks
    // after the edge that cleared it.
    localparam logic [25:0] LONG_LAST   = T_LONG - 26'd1;
    localparam logic [25:0] REPEAT_LAST = T_REPEAT - 26'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [25:0] cnt_q,       cnt_d;
    logic        din_q,       din_d;
    logic        press_q,     press_d;
    logic        short_p_q,   short_p_d;
    logic        long_p_q,    long_p_d;
    logic        rpt_p_q,     rpt_p_d;
    logic        held_q,      held_d;
    logic [7:0]  press_cnt_q, press_cnt_d;
    logic        rise_s;

    // Rising edge of the button level relative to the previous sample. din_q
    // resets high so a button held through reset does not count as a press.
    assign rise_s = bus.din & ~din_q;

    // Next-state, counter and event computation for the classifier FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        din_d       = bus.din;
        press_d     = 1'b0;
        short_p_d   = 1'b0;
        long_p_d    = 1'b0;
        rpt_p_d     = 1'b0;
        press_cnt_d = press_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = 26'd0;
                    press_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // Release is tested before the threshold, so a release on the
            // T_LONG-th edge is still a short press.
            ST_PRESSED: begin
                if (!bus.din) begin
                    state_d     = ST_IDLE;
                    short_p_d   = 1'b1;
                    press_cnt_d = press_cnt_q + 8'd1;
                    cnt_d       = 26'd0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d  = ST_LONG;
                    long_p_d = 1'b1;
                    cnt_d    = 26'd0;
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end

            // Long presses are not counted; release on a repeat edge
            // suppresses that repeat pulse.
            ST_LONG: begin
                if (!bus.din) begin
                    state_d = ST_IDLE;
                    cnt_d   = 26'd0;
                end else if (cnt_q == REPEAT_LAST) begin
                    rpt_p_d = 1'b1;
                    cnt_d   = 26'd0;
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 26'd0;
            end
        endcase

        // held follows the state being entered so it rises with press and
        // falls on the release edge.
        held_d = (state_d != ST_IDLE) ? 1'b1 : 1'b0;
    end

    // State, counter and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 26'd0;
            din_q       <= 1'b1;
            press_q     <= 1'b0;
            short_p_q   <= 1'b0;
            long_p_q    <= 1'b0;
            rpt_p_q     <= 1'b0;
            held_q      <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            din_q       <= din_d;
            press_q     <= press_d;
            short_p_q   <= short_p_d;
            long_p_q    <= long_p_d;
            rpt_p_q     <= rpt_p_d;
            held_q      <= held_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign bus.press     = press_q;
    assign bus.short_p   = short_p_q;
    assign bus.long_p    = long_p_q;
    assign bus.rpt_p     = rpt_p_q;
    assign bus.held      = held_q;
    assign bus.press_cnt = press_cnt_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// ---------------------------------------------------------------------------
// tb_btn_press_classifier
// Directed scenarios plus randomized press lengths for btn_press_classifier
// with T_LONG=16, T_REPEAT=4. Expected outputs come from a model that tracks
// how many edges a press has lasted and applies the classification rules
// arithmetically.
// ---------------------------------------------------------------------------
module tb_btn_press_classifier;

    localparam int TL = 16;
    localparam int TR = 4;

    logic clk;
    logic rst;

    btn_press_classifier_if bus_if ();

    btn_press_classifier #(
        .T_LONG   (26'd16),
        .T_REPEAT (26'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Model state: whether a press is in progress, edges since it began,
    // previous sampled level, and the expected outputs after the last edge.
    bit m_active;
    bit m_prev;
    int m_t;
    int e_cnt;
    bit e_press, e_short, e_long, e_rpt, e_held;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Apply the classification rules for one clock edge.
    task automatic model_edge(input bit d, input bit r);
        e_press = 1'b0;
        e_short = 1'b0;
        e_long  = 1'b0;
        e_rpt   = 1'b0;
        if (r) begin
            m_active = 1'b0;
            m_t      = 0;
            m_prev   = 1'b1;
            e_cnt    = 0;
        end else begin
            if (!m_active) begin
                if (d && !m_prev) begin
                    m_active = 1'b1;
                    m_t      = 0;
                    e_press  = 1'b1;
                end
            end else begin
                m_t++;
                if (!d) begin
                    m_active = 1'b0;
                    if (m_t <= TL) begin
                        e_short = 1'b1;
                        e_cnt   = (e_cnt + 1) % 256;
                    end
                end else if (m_t == TL) begin
                    e_long = 1'b1;
                end else if (m_t > TL && ((m_t - TL) % TR) == 0) begin
                    e_rpt = 1'b1;
                end
            end
            m_prev = d;
        end
        e_held = m_active;
    endtask

    // One clock: drive at the falling edge, model at the rising edge,
    // compare every output at the next falling edge.
    task automatic step(input bit d, input bit r);
        bus_if.din = d;
        rst        = r;
        @(posedge clk);
        model_edge(d, r);
        @(negedge clk);
        chk_eq("press",     32'(bus_if.press),     32'(e_press));
        chk_eq("short_p",   32'(bus_if.short_p),   32'(e_short));
        chk_eq("long_p",    32'(bus_if.long_p),    32'(e_long));
        chk_eq("rpt_p",     32'(bus_if.rpt_p),     32'(e_rpt));
        chk_eq("held",      32'(bus_if.held),      32'(e_held));
        chk_eq("press_cnt", 32'(bus_if.press_cnt), 32'(e_cnt));
    endtask

    task automatic hold(input int n, input bit d);
        for (int i = 0; i < n; i++) begin
            step(d, 1'b0);
        end
    endtask

    int seen_long;
    int seen_rpt;
    int cnt_before;

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        m_active   = 1'b0;
        m_prev     = 1'b1;
        m_t        = 0;
        e_cnt      = 0;
        rst        = 1'b1;
        bus_if.din = 1'b0;
        @(negedge clk);

        // Reset with button released, then idle.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        hold(5, 1'b0);
        chk_eq("reset_cnt", 32'(bus_if.press_cnt), 32'd0);

        // Short press of 5 edges.
        hold(5, 1'b1);
        hold(1, 1'b0);
        chk_eq("short_cnt", 32'(bus_if.press_cnt), 32'd1);
        chk_eq("short_pulse", 32'(bus_if.short_p), 32'd1);
        hold(3, 1'b0);

        // Long press held for 30 edges: long at k+16, repeats at 20/24/28.
        cnt_before = e_cnt;
        seen_long  = 0;
        seen_rpt   = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0);
            seen_long += int'(bus_if.long_p);
            seen_rpt  += int'(bus_if.rpt_p);
        end
        hold(1, 1'b0);
        chk_eq("long_count", 32'(seen_long), 32'd1);
        chk_eq("rpt_count",  32'(seen_rpt),  32'd3);
        chk_eq("long_cnt_kept", 32'(bus_if.press_cnt), 32'(cnt_before));
        hold(3, 1'b0);

        // Threshold boundary: 16 edges is short, 17 edges is long.
        hold(16, 1'b1);
        hold(1, 1'b0);
        chk_eq("bound16_short", 32'(bus_if.short_p), 32'd1);
        hold(2, 1'b0);
        hold(17, 1'b1);
        hold(1, 1'b0);
        chk_eq("bound17_short", 32'(bus_if.short_p), 32'd0);
        hold(2, 1'b0);

        // Button held through reset: no press until released and pressed.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        hold(10, 1'b1);
        chk_eq("held_rst_held", 32'(bus_if.held), 32'd0);
        hold(2, 1'b0);
        hold(3, 1'b1);
        hold(2, 1'b0);

        // 256 short presses: count reads 255 then wraps to 0.
        step(1'b0, 1'b1);
        hold(2, 1'b0);
        for (int p = 1; p <= 256; p++) begin
            hold(3, 1'b1);
            hold(1, 1'b0);
            if (p == 255) begin
                chk_eq("wrap_255", 32'(bus_if.press_cnt), 32'd255);
            end
            if (p == 256) begin
                chk_eq("wrap_0", 32'(bus_if.press_cnt), 32'd0);
            end
            hold(1, 1'b0);
        end

        // Randomized press lengths and gaps, occasional mid-press reset.
        for (int n = 0; n < 80; n++) begin
            int len;
            int gap;
            int rst_at;
            len    = int'($urandom_range(1, 40));
            gap    = int'($urandom_range(1, 4));
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            for (int c = 0; c < len; c++) begin
                step(1'b1, (c == rst_at) ? 1'b1 : 1'b0);
            end
            hold(gap, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
